// File: rtl/sample_iter.sv
// sample_iter: walks every subsample of a triangle's bounding box in raster order,
// one per cycle, holding the upstream bbox stage through halt_RnnnnL while busy.
module sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                          validTri_R13H,
  input  logic        [3:0]                             subSample_RnnnnU,
  output logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic                                          validSamp_R14H
);
  localparam logic WAIT_STATE = 1'b0;
  localparam logic TEST_STATE = 1'b1;
  logic state_q, state_d, valid_q, valid_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0] color_q, color_d;
  logic signed [SIGFIG-1:0] sx_q, sx_d, sy_q, sy_d, llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
  logic signed [SIGFIG-1:0] in_llx, in_lly, in_urx, in_ury, step;
  logic [1:0] ss_w_lg2;
  logic x_end, y_end, at_end, accept, single;
  assign in_llx = $signed(box_R13S[0][0]);
  assign in_lly = $signed(box_R13S[0][1]);
  assign in_urx = $signed(box_R13S[1][0]);
  assign in_ury = $signed(box_R13S[1][1]);
  assign ss_w_lg2 = subSample_RnnnnU[0] ? 2'd3 : subSample_RnnnnU[1] ? 2'd2 :
                    subSample_RnnnnU[2] ? 2'd1 : 2'd0;
  assign step = SIGFIG'(1) << (RADIX - int'(ss_w_lg2));
  assign x_end = sx_q + step > urx_q;
  assign y_end = sy_q + step > ury_q;
  assign at_end = x_end && y_end;
  assign halt_RnnnnL = (state_q == WAIT_STATE) || at_end;
  assign accept = halt_RnnnnL && validTri_R13H;
  // An inverted box on either axis collapses to its LL sample alone.
  assign single = (in_llx + step > in_urx && in_lly + step > in_ury) ||
                  in_urx < in_llx || in_ury < in_lly;
  always_comb begin
    tri_d = tri_q;
    color_d = color_q;
    llx_d = llx_q;
    urx_d = urx_q;
    ury_d = ury_q;
    sx_d = sx_q;
    sy_d = sy_q;
    valid_d = 1'b0;
    state_d = WAIT_STATE;
    if (accept) begin
      tri_d = tri_R13S;
      color_d = color_R13U;
      llx_d = in_llx;
      urx_d = in_urx;
      ury_d = in_ury;
      sx_d = in_llx;
      sy_d = in_lly;
      valid_d = 1'b1;
      state_d = single ? WAIT_STATE : TEST_STATE;
    end else if (state_q == TEST_STATE && !at_end) begin
      valid_d = 1'b1;
      state_d = TEST_STATE;
      sx_d = x_end ? llx_q : sx_q + step;
      sy_d = x_end ? sy_q + step : sy_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_STATE;
      valid_q <= 1'b0;
      tri_q <= '0;
      color_q <= '0;
      llx_q <= '0;
      urx_q <= '0;
      ury_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tri_q <= tri_d;
      color_q <= color_d;
      llx_q <= llx_d;
      urx_q <= urx_d;
      ury_q <= ury_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end
  assign tri_R14S = tri_q;
  assign color_R14U = color_q;
  assign sample_R14S = {sy_q, sx_q};
  assign validSamp_R14H = valid_q;
endmodule

// File: tb/tb_sample_iter.sv
// tb_sample_iter: directed vectors for the sample iterator with hand-computed samples.
module tb_sample_iter;
  logic clk = 1'b0;
  logic rst;
  logic signed [2:0][2:0][23:0] tri_R13S;
  logic [2:0][23:0] color_R13U;
  logic signed [1:0][1:0][23:0] box_R13S;
  logic validTri_R13H;
  logic [3:0] subSample_RnnnnU;
  logic halt_RnnnnL;
  logic signed [2:0][2:0][23:0] tri_R14S;
  logic [2:0][23:0] color_R14U;
  logic signed [1:0][23:0] sample_R14S;
  logic validSamp_R14H;
  int n_vec = 0;
  int n_bad = 0;
  localparam logic [215:0] TA = {9{24'h0A0B0C}};
  localparam logic [215:0] TB = {9{24'h123456}};
  localparam logic [71:0] CA = {3{24'h00FF00}};
  localparam logic [71:0] CB = {3{24'h0000FF}};

  sample_iter dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_R13S), .color_R13U(color_R13U),
    .box_R13S(box_R13S), .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
    .halt_RnnnnL(halt_RnnnnL), .tri_R14S(tri_R14S), .color_R14U(color_R14U),
    .sample_R14S(sample_R14S), .validSamp_R14H(validSamp_R14H)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int llx, input int lly, input int urx, input int ury);
    box_R13S[0][0] = 24'(llx);
    box_R13S[0][1] = 24'(lly);
    box_R13S[1][0] = 24'(urx);
    box_R13S[1][1] = 24'(ury);
  endtask

  task automatic exp_s(input string tag, input int x, input int y, input logic h);
    chk({tag, " valid"}, validSamp_R14H, 1'b1);
    chk({tag, " sample"}, sample_R14S, {24'(y), 24'(x)});
    chk({tag, " halt"}, halt_RnnnnL, h);
    tick();
  endtask

  task automatic run_box(input string tag, input int llx, input int lly, input int urx,
                         input int ury, input logic [3:0] ss, input int step, input int nx,
                         input int ny);
    subSample_RnnnnU = ss;
    tri_R13S = TA;
    color_R13U = CA;
    set_box(llx, lly, urx, ury);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    chk({tag, " tri"}, tri_R14S, TA);
    chk({tag, " color"}, color_R14U, CA);
    for (int j = 0; j < ny; j++)
      for (int i = 0; i < nx; i++)
        exp_s(tag, llx + i * step, lly + j * step, i == nx - 1 && j == ny - 1);
    chk({tag, " done valid"}, validSamp_R14H, 1'b0);
    chk({tag, " done halt"}, halt_RnnnnL, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    validTri_R13H = 1'b0;
    subSample_RnnnnU = 4'b1000;
    tri_R13S = '0;
    color_R13U = '0;
    box_R13S = '0;
    #2;
    chk("rst valid", validSamp_R14H, 1'b0);
    chk("rst halt", halt_RnnnnL, 1'b1);
    chk("rst sample", sample_R14S, 48'd0);
    @(negedge clk);
    rst = 1'b1;
    // reset mid-iteration of a 3x2 box
    tri_R13S = TA;
    color_R13U = CA;
    set_box(0, 0, 2048, 1024);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    exp_s("t1", 0, 0, 1'b0);
    chk("t1 2nd valid", validSamp_R14H, 1'b1);
    chk("t1 2nd sample", sample_R14S, {24'd0, 24'd1024});
    #1 rst = 1'b0;
    #1;
    chk("t1 async valid", validSamp_R14H, 1'b0);
    chk("t1 async halt", halt_RnnnnL, 1'b1);
    chk("t1 async sample", sample_R14S, 48'd0);
    chk("t1 async tri", tri_R14S, 216'd0);
    chk("t1 async color", color_R14U, 72'd0);
    #1 rst = 1'b1;
    repeat (5) begin
      tick();
      chk("t1 post valid", validSamp_R14H, 1'b0);
      chk("t1 post halt", halt_RnnnnL, 1'b1);
    end
    run_box("t2", 0, 0, 2048, 1024, 4'b1000, 1024, 3, 2);
    run_box("t3", 3072, 512, 3072, 512, 4'b1000, 1024, 1, 1);
    run_box("t4", 0, 0, 256, 256, 4'b0001, 128, 3, 3);
    run_box("degen", 1024, 1024, 0, 4096, 4'b1000, 1024, 1, 1);
    run_box("ss2", 512, 0, 1024, 0, 4'b0010, 256, 3, 1);
    // back-to-back: B waits with validTri high until A's last sample
    subSample_RnnnnU = 4'b1000;
    tri_R13S = TA;
    color_R13U = CA;
    set_box(0, 0, 2048, 1024);
    validTri_R13H = 1'b1;
    tick();
    tri_R13S = TB;
    color_R13U = CB;
    set_box(4096, 2048, 5120, 2048);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 3; i++) begin
        chk("t5 tri A", tri_R14S, TA);
        exp_s("t5a", i * 1024, j * 1024, i == 2 && j == 1);
      end
    validTri_R13H = 1'b0;
    chk("t5 tri B", tri_R14S, TB);
    chk("t5 color B", color_R14U, CB);
    exp_s("t5b", 4096, 2048, 1'b0);
    exp_s("t5b", 5120, 2048, 1'b1);
    chk("t5 done valid", validSamp_R14H, 1'b0);
    tri_R13S = TA;
    color_R13U = CA;
    set_box(0, 0, 0, 0);
    repeat (10) begin
      tick();
      chk("t6 valid", validSamp_R14H, 1'b0);
      chk("t6 halt", halt_RnnnnL, 1'b1);
    end
    chk("t6 sample hold", sample_R14S, {24'd2048, 24'd5120});
    chk("t6 tri hold", tri_R14S, TB);
    chk("t6 color hold", color_R14U, CB);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
